// File: rtl/exe_forward_ctrl_pkg.sv
// Shared encodings for the EXE forwarding scheduler: operand-select and
// store-data-select codes, plus the default register index width.
package exe_forward_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    SEL_OPERAND = 2'd0,
    SEL_ALU     = 2'd1,
    SEL_MEM     = 2'd2,
    SEL_WB      = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    MEMD_PIPE = 2'd0,
    MEMD_WB   = 2'd1
  } memd_e;

  // SEL_ALU is deliberately never returned: an ALU->ALU bypass would close a
  // combinational loop through EXE, so the nearest legal source is MEM.
  function automatic sel_e pick_sel(input logic exe_hit, input logic mem_hit);
    if (exe_hit) begin
      return SEL_MEM;
    end else if (mem_hit) begin
      return SEL_WB;
    end
    return SEL_OPERAND;
  endfunction

endpackage

// File: rtl/exe_forward_ctrl_fwd_match.sv
// Producer/consumer comparator: a tracking slot hits a source register only
// when it really writes a non-zero destination equal to that source.
module fwd_match #(
  parameter int W = 5
) (
  input  logic         slot_valid_i,
  input  logic         slot_regwrite_i,
  input  logic [W-1:0] slot_dest_i,
  input  logic [W-1:0] src_idx_i,
  input  logic         use_i,
  output logic         hit_o
);

  assign hit_o = use_i & slot_valid_i & slot_regwrite_i &
                 (slot_dest_i != '0) & (slot_dest_i == src_idx_i);

endmodule

// File: rtl/exe_forward_ctrl.sv
// EXE-stage hazard/forwarding scheduler: tracks the two older instructions and
// registers operand/store-data selects for the instruction leaving ID.
module exe_forward_ctrl
  import exe_forward_ctrl_pkg::*;
#(
  parameter bit LOAD_USE_STALL = 1'b1,
  parameter int NREGS_LOG2     = REG_IDX_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  Pipe_Stall_IN,
  input  logic                  Flush_IN,
  input  logic                  ID_Valid_IN,
  input  logic [NREGS_LOG2-1:0] ID_RegA_IN,
  input  logic [NREGS_LOG2-1:0] ID_RegB_IN,
  input  logic                  ID_UsesA_IN,
  input  logic                  ID_UsesB_IN,
  input  logic                  ID_MemWrite_IN,
  input  logic [NREGS_LOG2-1:0] ID_StoreReg_IN,
  input  logic [NREGS_LOG2-1:0] ID_WriteReg_IN,
  input  logic                  ID_RegWrite_IN,
  input  logic                  ID_MemRead_IN,
  output logic [1:0]            RegA_Select,
  output logic [1:0]            RegB_Select,
  output logic [1:0]            MEM_Data_select,
  output logic                  Stall_OUT
);

  localparam int NSRC = 3;  // 0: source A, 1: source B, 2: store data

  logic                  exe_valid_q, exe_regwrite_q, exe_load_q;
  logic [NREGS_LOG2-1:0] exe_dest_q;
  logic                  mem_valid_q, mem_regwrite_q;
  logic [NREGS_LOG2-1:0] mem_dest_q;

  logic [NREGS_LOG2-1:0] src_idx [NSRC];
  logic                  src_use [NSRC];
  logic                  exe_hit [NSRC];
  logic                  mem_hit [NSRC];

  logic  id_live, load_use, store_stall, advance;
  sel_e  sel_a_d, sel_b_d;
  memd_e memd_d;

  assign src_idx[0] = ID_RegA_IN;
  assign src_idx[1] = ID_RegB_IN;
  assign src_idx[2] = ID_StoreReg_IN;
  assign src_use[0] = ID_UsesA_IN;
  assign src_use[1] = ID_UsesB_IN;
  assign src_use[2] = ID_MemWrite_IN;

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_match
      fwd_match #(.W(NREGS_LOG2)) u_exe (
        .slot_valid_i    (exe_valid_q),
        .slot_regwrite_i (exe_regwrite_q),
        .slot_dest_i     (exe_dest_q),
        .src_idx_i       (src_idx[gi]),
        .use_i           (src_use[gi]),
        .hit_o           (exe_hit[gi])
      );
      fwd_match #(.W(NREGS_LOG2)) u_mem (
        .slot_valid_i    (mem_valid_q),
        .slot_regwrite_i (mem_regwrite_q),
        .slot_dest_i     (mem_dest_q),
        .src_idx_i       (src_idx[gi]),
        .use_i           (src_use[gi]),
        .hit_o           (mem_hit[gi])
      );
    end
  endgenerate

  assign id_live  = ID_Valid_IN & ~Flush_IN;
  assign load_use = LOAD_USE_STALL & exe_load_q & (exe_hit[0] | exe_hit[1]);
  // A store whose data producer sits in MEM waits one cycle so the producer
  // reaches WB, where the write-first register file read covers it.
  assign store_stall = ID_MemWrite_IN & mem_hit[2] & ~exe_hit[2];
  assign Stall_OUT   = id_live & (load_use | store_stall);
  assign advance     = id_live & ~Stall_OUT;

  always_comb begin
    sel_a_d = SEL_OPERAND;
    sel_b_d = SEL_OPERAND;
    memd_d  = MEMD_PIPE;
    if (advance) begin
      sel_a_d = pick_sel(exe_hit[0], mem_hit[0]);
      sel_b_d = pick_sel(exe_hit[1], mem_hit[1]);
      if (exe_hit[2]) begin
        memd_d = MEMD_WB;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      exe_valid_q     <= 1'b0;
      exe_regwrite_q  <= 1'b0;
      exe_load_q      <= 1'b0;
      exe_dest_q      <= '0;
      mem_valid_q     <= 1'b0;
      mem_regwrite_q  <= 1'b0;
      mem_dest_q      <= '0;
      RegA_Select     <= 2'd0;
      RegB_Select     <= 2'd0;
      MEM_Data_select <= 2'd0;
    end else if (!Pipe_Stall_IN) begin
      mem_valid_q     <= exe_valid_q;
      mem_regwrite_q  <= exe_regwrite_q;
      mem_dest_q      <= exe_dest_q;
      exe_valid_q     <= advance;
      exe_regwrite_q  <= advance & ID_RegWrite_IN;
      exe_load_q      <= advance & ID_MemRead_IN;
      exe_dest_q      <= advance ? ID_WriteReg_IN : '0;
      RegA_Select     <= sel_a_d;
      RegB_Select     <= sel_b_d;
      MEM_Data_select <= memd_d;
    end
  end

endmodule

// File: tb/tb_exe_forward_ctrl.sv
// Scoreboard bench for exe_forward_ctrl: directed instruction sequences with
// expected selects queued at drive time and compared after the clock edge.
module tb_exe_forward_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       Pipe_Stall_IN, Flush_IN, ID_Valid_IN;
  logic [4:0] ID_RegA_IN, ID_RegB_IN, ID_StoreReg_IN, ID_WriteReg_IN;
  logic       ID_UsesA_IN, ID_UsesB_IN, ID_MemWrite_IN, ID_RegWrite_IN, ID_MemRead_IN;
  logic [1:0] sel_a, sel_b, memd, sel_a0, sel_b0, memd0;
  logic       stall, stall0;

  typedef struct {
    string      tag;
    logic [1:0] a, b, m, a0;
    logic       chk0;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic chk0     = 1'b0;
  logic es0      = 1'b0;
  logic [1:0] ea0 = 2'd0;

  always #5 CLK = ~CLK;

  exe_forward_ctrl #(.LOAD_USE_STALL(1'b1), .NREGS_LOG2(5)) dut (
    .CLK(CLK), .RESET(RESET), .Pipe_Stall_IN(Pipe_Stall_IN), .Flush_IN(Flush_IN),
    .ID_Valid_IN(ID_Valid_IN), .ID_RegA_IN(ID_RegA_IN), .ID_RegB_IN(ID_RegB_IN),
    .ID_UsesA_IN(ID_UsesA_IN), .ID_UsesB_IN(ID_UsesB_IN), .ID_MemWrite_IN(ID_MemWrite_IN),
    .ID_StoreReg_IN(ID_StoreReg_IN), .ID_WriteReg_IN(ID_WriteReg_IN),
    .ID_RegWrite_IN(ID_RegWrite_IN), .ID_MemRead_IN(ID_MemRead_IN),
    .RegA_Select(sel_a), .RegB_Select(sel_b), .MEM_Data_select(memd), .Stall_OUT(stall)
  );

  exe_forward_ctrl #(.LOAD_USE_STALL(1'b0), .NREGS_LOG2(5)) dut0 (
    .CLK(CLK), .RESET(RESET), .Pipe_Stall_IN(Pipe_Stall_IN), .Flush_IN(Flush_IN),
    .ID_Valid_IN(ID_Valid_IN), .ID_RegA_IN(ID_RegA_IN), .ID_RegB_IN(ID_RegB_IN),
    .ID_UsesA_IN(ID_UsesA_IN), .ID_UsesB_IN(ID_UsesB_IN), .ID_MemWrite_IN(ID_MemWrite_IN),
    .ID_StoreReg_IN(ID_StoreReg_IN), .ID_WriteReg_IN(ID_WriteReg_IN),
    .ID_RegWrite_IN(ID_RegWrite_IN), .ID_MemRead_IN(ID_MemRead_IN),
    .RegA_Select(sel_a0), .RegB_Select(sel_b0), .MEM_Data_select(memd0), .Stall_OUT(stall0)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic id_set(input logic v, input logic [4:0] ra, input logic ua,
                        input logic [4:0] rb, input logic ub, input logic [4:0] wr,
                        input logic rw, input logic mr, input logic mw,
                        input logic [4:0] sr);
    ID_Valid_IN    = v;
    ID_RegA_IN     = ra;
    ID_UsesA_IN    = ua;
    ID_RegB_IN     = rb;
    ID_UsesB_IN    = ub;
    ID_WriteReg_IN = wr;
    ID_RegWrite_IN = rw;
    ID_MemRead_IN  = mr;
    ID_MemWrite_IN = mw;
    ID_StoreReg_IN = sr;
  endtask

  // Called just after a falling edge with ID inputs already driven.
  task automatic cycle(input string tag, input logic es, input logic [1:0] ea,
                       input logic [1:0] eb, input logic [1:0] em);
    exp_t e;
    #1;
    check_val({tag, "_stall"}, int'(stall), int'(es));
    if (chk0) check_val({tag, "_stall0"}, int'(stall0), int'(es0));
    e.tag = tag; e.a = ea; e.b = eb; e.m = em; e.a0 = ea0; e.chk0 = chk0;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check_val({e.tag, "_selA"}, int'(sel_a), int'(e.a));
    check_val({e.tag, "_selB"}, int'(sel_b), int'(e.b));
    check_val({e.tag, "_memd"}, int'(memd), int'(e.m));
    if (e.chk0) begin
      check_val({e.tag, "_selA0"}, int'(sel_a0), int'(e.a0));
      check_val({e.tag, "_selB0"}, int'(sel_b0), 0);
      check_val({e.tag, "_memd0"}, int'(memd0), 0);
    end
    @(negedge CLK);
  endtask

  task automatic idle2();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("idle", 0, 0, 0, 0);
    cycle("idle", 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b0; Pipe_Stall_IN = 1'b0; Flush_IN = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge CLK);
    check_val("rst_selA", int'(sel_a), 0);
    check_val("rst_selB", int'(sel_b), 0);
    check_val("rst_memd", int'(memd), 0);
    check_val("rst_stall", int'(stall), 0);
    RESET = 1'b1;
    idle2();

    // EXE forward: add $3 then sub $4,$3,$5
    id_set(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); cycle("add3", 0, 0, 0, 0);
    id_set(1, 3, 1, 5, 1, 4, 1, 0, 0, 0); cycle("sub_exe_fwd", 0, 2, 0, 0);

    // Nearest producer wins, MEM-only forward, use flag, register 0
    id_set(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); cycle("add3_a", 0, 0, 0, 0);
    id_set(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); cycle("add3_b", 0, 0, 0, 0);
    id_set(1, 3, 1, 3, 1, 9, 1, 0, 0, 0); cycle("nearest", 0, 2, 2, 0);
    id_set(1, 3, 1, 3, 0, 10, 1, 0, 0, 0); cycle("mem_fwd", 0, 3, 0, 0);
    id_set(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); cycle("wr_r0", 0, 0, 0, 0);
    id_set(1, 0, 1, 0, 1, 11, 1, 0, 0, 0); cycle("rd_r0", 0, 0, 0, 0);
    idle2();

    // Load-use: both parameterisations side by side
    chk0 = 1'b1; es0 = 1'b0; ea0 = 2'd0;
    id_set(1, 0, 0, 0, 0, 3, 1, 1, 0, 0); cycle("lw3", 0, 0, 0, 0);
    ea0 = 2'd2;
    id_set(1, 3, 1, 5, 1, 4, 1, 0, 0, 0); cycle("lu_stall", 1, 0, 0, 0);
    ea0 = 2'd3;
    cycle("lu_after", 0, 3, 0, 0);
    chk0 = 1'b0;
    idle2();

    // Store data forwarding and store-data stall
    id_set(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); cycle("add7", 0, 0, 0, 0);
    id_set(1, 1, 1, 0, 0, 0, 0, 0, 1, 7); cycle("sw_exe", 0, 0, 0, 1);
    id_set(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); cycle("add7_b", 0, 0, 0, 0);
    id_set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle("nop", 0, 0, 0, 0);
    id_set(1, 1, 1, 0, 0, 0, 0, 0, 1, 7); cycle("sw_mem_stall", 1, 0, 0, 0);
    cycle("sw_mem_after", 0, 0, 0, 0);
    id_set(1, 0, 0, 0, 0, 7, 1, 1, 0, 0); cycle("lw7", 0, 0, 0, 0);
    id_set(1, 1, 1, 0, 0, 0, 0, 0, 1, 7); cycle("sw_load", 0, 0, 0, 1);
    idle2();

    // Flush beats load-use; flushed slot is a bubble
    id_set(1, 0, 0, 0, 0, 3, 1, 1, 0, 0); cycle("lw3_f", 0, 0, 0, 0);
    id_set(1, 3, 1, 5, 1, 4, 1, 0, 0, 0);
    Flush_IN = 1'b1; cycle("flush", 0, 0, 0, 0);
    Flush_IN = 1'b0; cycle("post_flush", 0, 3, 0, 0);
    idle2();

    // External freeze during a load-use hazard
    id_set(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); cycle("add5", 0, 0, 0, 0);
    id_set(1, 5, 1, 0, 0, 3, 1, 1, 0, 0); cycle("lw3_fwd5", 0, 2, 0, 0);
    id_set(1, 3, 1, 5, 1, 4, 1, 0, 0, 0);
    Pipe_Stall_IN = 1'b1;
    for (int i = 0; i < 3; i++) cycle("freeze", 1, 2, 0, 0);
    Pipe_Stall_IN = 1'b0;
    cycle("freeze_bubble", 1, 0, 0, 0);
    cycle("freeze_after", 0, 3, 0, 0);

    // Asynchronous reset in the middle of a hazard
    id_set(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); cycle("add5_r", 0, 0, 0, 0);
    id_set(1, 5, 1, 0, 0, 3, 1, 1, 0, 0); cycle("lw3_r", 0, 2, 0, 0);
    id_set(1, 3, 1, 5, 1, 4, 1, 0, 0, 0);
    #1;
    check_val("pre_rst_stall", int'(stall), 1);
    RESET = 1'b0;
    #1;
    check_val("midrst_selA", int'(sel_a), 0);
    check_val("midrst_stall", int'(stall), 0);
    @(negedge CLK);
    RESET = 1'b1;
    cycle("post_reset", 0, 0, 0, 0);

    check_val("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
